// File: rtl/pong_pkg.sv
// Shared constants for the pong match controller:
// state codes, default timing/score limits, winner codes.
package pong_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SERVE    = 3'd1;
  localparam logic [2:0] ST_PLAY     = 3'd2;
  localparam logic [2:0] ST_PAUSE    = 3'd3;
  localparam logic [2:0] ST_POINT    = 3'd4;
  localparam logic [2:0] ST_GAMEOVER = 3'd5;

  localparam int WIN_SCORE_DEF    = 11;
  localparam int SERVE_FRAMES_DEF = 120;
  localparam int POINT_FRAMES_DEF = 60;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;

  function automatic logic [7:0] sat_dec(
    input logic [7:0] v
  );
    return (v == 8'd0) ? 8'd0 : v - 8'd1;
  endfunction

endpackage

// File: rtl/pong_match_ctrl_if.sv
// Datapath <-> match controller bundle.
// master: datapath side; slave: controller side.
interface pong_match_ctrl_if;

  logic       frame_tick;
  logic [4:0] score1;
  logic [4:0] score2;
  logic       game_reset;
  logic       run_enable;
  logic [2:0] state;
  logic [1:0] winner;
  logic [7:0] countdown;

  modport master (
    output frame_tick, score1, score2,
    input  game_reset, run_enable,
    input  state, winner, countdown
  );

  modport slave (
    input  frame_tick, score1, score2,
    output game_reset, run_enable,
    output state, winner, countdown
  );

endinterface

// File: rtl/pong_btn_edge.sv
// Button 2-flop synchronizer + rising-edge detector.
// Ports: CLK, resetN, btn (raw) -> press (1-CLK pulse).
module pong_btn_edge (
  input  logic CLK,
  input  logic resetN,
  input  logic btn,
  output logic press
);

  logic       s0;
  logic       s1;
  logic       prev;
  logic       armed;
  logic [1:0] vld;

  // armed only after a synchronized low is seen,
  // so a button held through reset gives no edge
  always_ff @(posedge CLK or negedge resetN) begin
    if (!resetN) begin
      s0    <= 1'b0;
      s1    <= 1'b0;
      prev  <= 1'b0;
      vld   <= 2'b00;
      armed <= 1'b0;
    end else begin
      s0   <= btn;
      s1   <= s0;
      prev <= s1;
      vld  <= {vld[0], 1'b1};
      if (vld[1] && !s1)
        armed <= 1'b1;
    end
  end

  assign press = s1 & ~prev & armed;

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match FSM: serve/play/pause/point/gameover.
// Ports: CLK, resetN, start_btn, pause_btn, bus (slave).
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = WIN_SCORE_DEF,
  parameter int SERVE_FRAMES = SERVE_FRAMES_DEF,
  parameter int POINT_FRAMES = POINT_FRAMES_DEF
) (
  input  logic CLK,
  input  logic resetN,
  input  logic start_btn,
  input  logic pause_btn,
  pong_match_ctrl_if.slave bus
);

  localparam logic [4:0] WIN = 5'(WIN_SCORE);
  localparam logic [7:0] SRV = 8'(SERVE_FRAMES);
  localparam logic [7:0] PNT = 8'(POINT_FRAMES);

  logic       start_p;
  logic       pause_p;
  logic [2:0] st_q;
  logic [2:0] st_d;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic [1:0] win_q;
  logic [1:0] win_d;
  logic       rst_q;
  logic       rst_d;
  logic       run_q;
  logic [4:0] s1_q;
  logic [4:0] s2_q;
  logic       inc1;
  logic       inc2;

  pong_btn_edge u_start (
    .CLK    (CLK),
    .resetN (resetN),
    .btn    (start_btn),
    .press  (start_p)
  );

  pong_btn_edge u_pause (
    .CLK    (CLK),
    .resetN (resetN),
    .btn    (pause_btn),
    .press  (pause_p)
  );

  assign inc1 = bus.score1 > s1_q;
  assign inc2 = bus.score2 > s2_q;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    win_d = win_q;
    rst_d = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (start_p) begin
          st_d  = ST_SERVE;
          cnt_d = SRV;
          rst_d = 1'b1;
        end
      end
      ST_SERVE: begin
        if (bus.frame_tick) begin
          if (cnt_q <= 8'd1) begin
            st_d  = ST_PLAY;
            cnt_d = 8'd0;
          end else begin
            cnt_d = sat_dec(cnt_q);
          end
        end
      end
      ST_PLAY: begin
        // scoring outranks pause; p1 first
        if (inc1 && bus.score1 >= WIN) begin
          st_d  = ST_GAMEOVER;
          win_d = WIN_P1;
        end else if (inc2 && bus.score2 >= WIN) begin
          st_d  = ST_GAMEOVER;
          win_d = WIN_P2;
        end else if (inc1 || inc2) begin
          st_d  = ST_POINT;
          cnt_d = PNT;
        end else if (pause_p) begin
          st_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (pause_p)
          st_d = ST_PLAY;
      end
      ST_POINT: begin
        if (bus.frame_tick) begin
          if (cnt_q <= 8'd1) begin
            st_d  = ST_SERVE;
            cnt_d = SRV;
          end else begin
            cnt_d = sat_dec(cnt_q);
          end
        end
      end
      ST_GAMEOVER: begin
        if (start_p) begin
          st_d  = ST_SERVE;
          cnt_d = SRV;
          win_d = WIN_NONE;
          rst_d = 1'b1;
        end
      end
      default: begin
        st_d  = ST_IDLE;
        cnt_d = 8'd0;
        win_d = WIN_NONE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge resetN) begin
    if (!resetN) begin
      st_q  <= ST_IDLE;
      cnt_q <= 8'd0;
      win_q <= WIN_NONE;
      rst_q <= 1'b0;
      run_q <= 1'b0;
      s1_q  <= 5'd0;
      s2_q  <= 5'd0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      win_q <= win_d;
      rst_q <= rst_d;
      run_q <= (st_d == ST_PLAY);
      s1_q  <= bus.score1;
      s2_q  <= bus.score2;
    end
  end

  assign bus.state      = st_q;
  assign bus.countdown  = cnt_q;
  assign bus.winner     = win_q;
  assign bus.game_reset = rst_q;
  assign bus.run_enable = run_q;

endmodule

// File: doc/pong_match_ctrl.md
PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 11: points that end a match (1..31).
REQ-002 Parameter SERVE_FRAMES, default 120: frames held in SERVE before play (1..255).
REQ-003 Parameter POINT_FRAMES, default 60: frames held in POINT after a score (1..255).
REQ-004 CLK  in  1  single system clock; all state changes on its rising edge.
REQ-005 resetN  in  1  one clock; reset is asynchronous and active-low.
REQ-006 frame_tick  in  1  one-CLK pulse per frame (datapath screen-refresh strobe).
REQ-007 start_btn  in  1  raw asynchronous start button, active-high.
REQ-008 pause_btn  in  1  raw asynchronous pause button, active-high.
REQ-009 score1  in  5  player-1 score from the datapath.
REQ-010 score2  in  5  player-2 score from the datapath.
REQ-011 game_reset  out  1  one-CLK pulse that clears the datapath (scores, ball, paddles).
REQ-012 run_enable  out  1  high only in PLAY; gates ball motion and paddle buttons.
REQ-013 state  out  3  encoded current state.
REQ-014 winner  out  2  0 none, 1 player 1, 2 player 2.
REQ-015 countdown  out  8  frames remaining in SERVE/POINT; 0 elsewhere.

Function
REQ-016 Each button SHALL pass through a 2-flop synchronizer plus rising-edge detector; every "press" below means one detected edge, 3 CLK after the raw rise.
REQ-017 States SHALL be IDLE=0, SERVE=1, PLAY=2, PAUSE=3, POINT=4, GAMEOVER=5; codes 6-7 SHALL return to IDLE on the next CLK.
REQ-018 IDLE: start press -> game_reset pulse in the same cycle the state changes, go SERVE, countdown=SERVE_FRAMES.
REQ-019 SERVE: countdown decrements by 1 per frame_tick; a frame_tick seen at countdown==1 -> PLAY, countdown=0.
REQ-020 PLAY: run_enable=1; a score increase is detected by comparing score1/score2 against registers latched every CLK.
REQ-021 PLAY, score increase with new value >= WIN_SCORE -> GAMEOVER, winner set to that player, same cycle.
REQ-022 PLAY, score increase below WIN_SCORE -> POINT, countdown=POINT_FRAMES.
REQ-023 PLAY, pause press with no score change -> PAUSE; score change SHALL take priority over pause in the same cycle.
REQ-024 PAUSE: run_enable=0; pause press -> PLAY; start press and frame_tick ignored.
REQ-025 POINT: countdown decrements per frame_tick; frame_tick at countdown==1 -> SERVE, countdown=SERVE_FRAMES.
REQ-026 GAMEOVER: winner held; start press -> game_reset pulse, winner=0, SERVE, countdown=SERVE_FRAMES.
REQ-027 Both scores increasing in one cycle: player 1 evaluated first (winner=1 if both reach WIN_SCORE).
REQ-028 Score decreases (datapath clear) SHALL only reload the latched copies, never trigger a transition.
REQ-029 Countdown SHALL never wrap below 0; start/pause presses in SERVE and POINT are ignored.
REQ-030 game_reset SHALL be exactly one CLK wide and never asserted outside REQ-018/REQ-026.

Reset
REQ-031 resetN low SHALL immediately force state=IDLE, game_reset=0, run_enable=0, winner=0, countdown=0, latched scores=0, synchronizer and edge flops=0.
REQ-032 Release of resetN SHALL not itself produce a button edge even if a button is held.
REQ-033 Reset asserted mid-SERVE/PLAY/POINT SHALL abandon the match with no game_reset pulse.

Structure
REQ-034 State encodings, WIN_SCORE/SERVE_FRAMES/POINT_FRAMES defaults and winner codes SHALL live in shared package pong_pkg.
REQ-035 Synchronizer + edge detector SHALL be one sub-module, pong_btn_edge, instantiated twice.
REQ-036 run_enable, game_reset, state, winner and countdown SHALL be registered outputs.

Verification
REQ-037 Reset, start press -> game_reset one pulse, state=1, countdown=120; 120 frame_ticks -> state=2, run_enable=1.
REQ-038 In PLAY, score1 0->1 -> state=4, countdown=60, run_enable=0; 60 ticks -> state=1, countdown=120.
REQ-039 In PLAY, score2 10->11 -> state=5, winner=2; start press -> game_reset pulse, winner=0, state=1.
REQ-040 In PLAY, pause press -> state=3, frame_ticks leave countdown 0; second press -> state=2.
REQ-041 Pause press and score1 increase in same cycle -> state=4, not 3; score1 5->0 in PLAY -> state stays 2.
REQ-042 resetN low mid-SERVE with countdown=37 -> all outputs 0 asynchronously; held start button at release -> stays IDLE.
